// File: rtl/iic_bus_arbiter_if.sv
// Bundle between the register-access requesters, the arbiter and the shared IIC byte engine.
//   Requester side : req, req_wr, req_dev, req_addr, req_wdata (in) / gnt, done, err, rdata (out)
//   Engine side    : iic_trig, w_r, device_id, addr, data_in (out) / busy, data_out (in)
// The master modport is taken by the arbiter, the slave modport by the surrounding logic.
interface iic_bus_arbiter_if #(
    parameter int N = 2
) ();
    logic [N-1:0]    req;
    logic [N-1:0]    req_wr;
    logic [8*N-1:0]  req_dev;
    logic [16*N-1:0] req_addr;
    logic [8*N-1:0]  req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic [7:0]      rdata;
    logic            iic_trig;
    logic            w_r;
    logic [7:0]      device_id;
    logic [15:0]     addr;
    logic [7:0]      data_in;
    logic            busy;
    logic [7:0]      data_out;

    modport master (
        input  req, req_wr, req_dev, req_addr, req_wdata, busy, data_out,
        output gnt, done, err, rdata, iic_trig, w_r, device_id, addr, data_in
    );

    modport slave (
        output req, req_wr, req_dev, req_addr, req_wdata, busy, data_out,
        input  gnt, done, err, rdata, iic_trig, w_r, device_id, addr, data_in
    );
endinterface

// File: rtl/iic_bus_arbiter.sv
// Round-robin arbiter sharing one IIC byte engine between N register-access requesters.
// One register byte is transferred per grant; the owner gets done (plus err on timeout)
// and, for reads, the byte on rdata.
// Ports:
//   clk  - system clock, all logic on posedge
//   rst  - asynchronous active-high reset
//   bus  - iic_bus_arbiter_if.master: requester handshake (req/gnt/done/err/rdata)
//          and engine command/status (iic_trig/w_r/device_id/addr/data_in/busy/data_out)
module iic_bus_arbiter #(
    parameter int N       = 2,
    parameter int TMO_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    iic_bus_arbiter_if.master bus
);
    localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam int PW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRIG  = 3'd1;
    localparam logic [2:0] S_WAITB = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]    state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [CW-1:0] tmo_cnt;
    logic          busy_d;

    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] cand;
    logic [N-1:0]  pick_oh;
    logic          sel_wr;
    logic [7:0]    sel_dev;
    logic [15:0]   sel_addr;
    logic [7:0]    sel_wdata;

    // Search from rr_ptr upward with wrap; the first pending requester wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_oh  = '0;
        cand     = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(rr_ptr) + i) % N);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld      = 1'b1;
                pick_idx      = cand;
                pick_oh[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_wr    = 1'b1;
        sel_dev   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == PW'(i)) begin
                sel_wr    = bus.req_wr[i];
                sel_dev   = bus.req_dev[8*i +: 8];
                sel_addr  = bus.req_addr[16*i +: 16];
                sel_wdata = bus.req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            tmo_cnt       <= '0;
            busy_d        <= 1'b0;
            bus.gnt       <= '0;
            bus.done      <= '0;
            bus.err       <= '0;
            bus.rdata     <= '0;
            bus.iic_trig  <= 1'b0;
            bus.w_r       <= 1'b1;
            bus.device_id <= '0;
            bus.addr      <= '0;
            bus.data_in   <= '0;
        end else begin
            busy_d       <= bus.busy;
            bus.iic_trig <= 1'b0;
            bus.done     <= '0;
            bus.err      <= '0;
            case (state)
                S_IDLE: begin
                    // Engine fields only change here, so they stay stable for the whole grant.
                    if (pick_vld) begin
                        owner         <= pick_idx;
                        bus.gnt       <= pick_oh;
                        bus.w_r       <= sel_wr;
                        bus.device_id <= sel_dev;
                        bus.addr      <= sel_addr;
                        bus.data_in   <= sel_wdata;
                        state         <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    bus.iic_trig <= 1'b1;
                    tmo_cnt      <= '0;
                    state        <= S_WAITB;
                end
                S_WAITB: begin
                    // A busy that is already high (stale) is accepted; RUN then waits for its fall.
                    if (bus.busy) begin
                        tmo_cnt <= '0;
                        state   <= S_RUN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.done <= bus.gnt;
                        bus.err  <= bus.gnt;
                        state    <= S_FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (busy_d && !bus.busy) begin
                        if (!bus.w_r) begin
                            bus.rdata <= bus.data_out;
                        end
                        bus.done <= bus.gnt;
                        state    <= S_FIN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.done <= bus.gnt;
                        bus.err  <= bus.gnt;
                        state    <= S_FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    // Advancing past the owner lets every other pending requester go first.
                    bus.gnt <= '0;
                    rr_ptr  <= PW'((int'(owner) + 1) % N);
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iic_bus_arbiter.sv
`timescale 1ns/1ps
module tb_iic_bus_arbiter;
    localparam int N = 2;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    iic_bus_arbiter_if #(.N(N)) a_if ();
    iic_bus_arbiter_if #(.N(N)) b_if ();

    iic_bus_arbiter #(.N(N), .TMO_CYC(1000)) dut_a (.clk(clk), .rst(rst_a), .bus(a_if));
    iic_bus_arbiter #(.N(N), .TMO_CYC(16))   dut_b (.clk(clk), .rst(rst_b), .bus(b_if));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    typedef struct {
        int         idx;
        logic       err;
        logic       rd;
        logic [7:0] rdata;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    task automatic push_a(input int idx, input logic e, input logic rd, input logic [7:0] rv);
        exp_t x;
        x.idx = idx; x.err = e; x.rd = rd; x.rdata = rv;
        qa.push_back(x);
    endtask

    task automatic push_b(input int idx, input logic e, input logic rd, input logic [7:0] rv);
        exp_t x;
        x.idx = idx; x.err = e; x.rd = rd; x.rdata = rv;
        qb.push_back(x);
    endtask

    // Engine models: busy rises the cycle after iic_trig, stays high eng_len cycles.
    int         eng_len_a = 20;
    logic [7:0] eng_rd_a  = 8'h00;
    logic       eng_en_b  = 1'b1;
    initial begin
        a_if.busy = 1'b0; a_if.data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (a_if.iic_trig) begin
                @(negedge clk); a_if.busy = 1'b1;
                repeat (eng_len_a) @(negedge clk);
                a_if.data_out = eng_rd_a; a_if.busy = 1'b0;
            end
        end
    end

    initial begin
        b_if.busy = 1'b0; b_if.data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (b_if.iic_trig && eng_en_b) begin
                @(negedge clk); b_if.busy = 1'b1;
                repeat (5) @(negedge clk);
                b_if.data_out = 8'hA5; b_if.busy = 1'b0;
            end
        end
    end

    // Monitor A: pops the scoreboard on every done pulse.
    int         done_cnt_a = 0, trig_cnt_a = 0, gnt_cnt_a = 0;
    logic       busy_last_a = 1'b0;
    logic [1:0] gnt_last_a  = 2'b00;
    logic [7:0] model_rd_a  = 8'h00;
    always begin
        @(posedge clk); #1;
        if (!rst_a) begin
            check("a_gnt_onehot0", 32'($onehot0(a_if.gnt)), 32'd1);
            check("a_err_without_done", 32'(a_if.err & ~a_if.done), 32'd0);
            if (a_if.gnt != 2'b00 && gnt_last_a == 2'b00) gnt_cnt_a++;
            if (a_if.iic_trig) begin
                trig_cnt_a++;
                check("a_trig_with_gnt", 32'($onehot(a_if.gnt)), 32'd1);
            end
            if (a_if.done != 2'b00) begin
                done_cnt_a++;
                if (qa.size() == 0) begin
                    check("a_unexpected_done", 32'(a_if.done), 32'd0);
                end else begin
                    ea = qa.pop_front();
                    if (ea.rd) model_rd_a = ea.rdata;
                    check("a_done_owner", 32'(a_if.done), 32'd1 << ea.idx);
                    check("a_err", 32'(a_if.err), ea.err ? (32'd1 << ea.idx) : 32'd0);
                    check("a_rdata", 32'(a_if.rdata), 32'(model_rd_a));
                    if (!ea.err) check("a_done_at_busy_fall", 32'({busy_last_a, a_if.busy}), 32'd2);
                end
            end
        end
        busy_last_a = a_if.busy;
        gnt_last_a  = a_if.gnt;
    end

    // Monitor B: timeout instance.
    int         done_cnt_b = 0, trig_cnt_b = 0, last_trig_b = 0;
    logic       busy_last_b = 1'b0;
    logic [7:0] model_rd_b  = 8'h00;
    always begin
        @(posedge clk); #1;
        if (!rst_b) begin
            check("b_gnt_onehot0", 32'($onehot0(b_if.gnt)), 32'd1);
            if (b_if.iic_trig) begin
                trig_cnt_b++;
                last_trig_b = cyc;
            end
            if (b_if.done != 2'b00) begin
                done_cnt_b++;
                if (qb.size() == 0) begin
                    check("b_unexpected_done", 32'(b_if.done), 32'd0);
                end else begin
                    eb = qb.pop_front();
                    if (eb.rd) model_rd_b = eb.rdata;
                    check("b_done_owner", 32'(b_if.done), 32'd1 << eb.idx);
                    check("b_err", 32'(b_if.err), eb.err ? (32'd1 << eb.idx) : 32'd0);
                    check("b_rdata", 32'(b_if.rdata), 32'(model_rd_b));
                    if (eb.err) check("b_tmo_latency", 32'(cyc - last_trig_b), 32'd16);
                    else        check("b_done_at_busy_fall", 32'({busy_last_b, b_if.busy}), 32'd2);
                end
            end
        end
        busy_last_b = b_if.busy;
    end

    task automatic drive_a(input int idx, input logic wr, input logic [7:0] dev,
                           input logic [15:0] ad, input logic [7:0] wd);
        if (idx == 0) begin
            a_if.req_wr[0] = wr; a_if.req_dev[7:0] = dev; a_if.req_addr[15:0] = ad; a_if.req_wdata[7:0] = wd;
        end else begin
            a_if.req_wr[1] = wr; a_if.req_dev[15:8] = dev; a_if.req_addr[31:16] = ad; a_if.req_wdata[15:8] = wd;
        end
    endtask

    task automatic wait_done(input int which, input int target, input int budget, input string name);
        int k = 0;
        while (((which == 0) ? done_cnt_a : done_cnt_b) < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'((which == 0) ? done_cnt_a : done_cnt_b), 32'(target));
    endtask

    task automatic wait_busy_a(input logic lvl, input int budget, input string name);
        int k = 0;
        while (a_if.busy !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(a_if.busy), 32'(lvl));
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_gnt"},       32'(a_if.gnt),       32'd0);
        check({tag, "_done"},      32'(a_if.done),      32'd0);
        check({tag, "_err"},       32'(a_if.err),       32'd0);
        check({tag, "_rdata"},     32'(a_if.rdata),     32'd0);
        check({tag, "_iic_trig"},  32'(a_if.iic_trig),  32'd0);
        check({tag, "_w_r"},       32'(a_if.w_r),       32'd1);
        check({tag, "_device_id"}, 32'(a_if.device_id), 32'd0);
        check({tag, "_addr"},      32'(a_if.addr),      32'd0);
        check({tag, "_data_in"},   32'(a_if.data_in),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.req = '0; a_if.req_wr = '0; a_if.req_dev = '0; a_if.req_addr = '0; a_if.req_wdata = '0;
        b_if.req = '0; b_if.req_wr = '0; b_if.req_dev = '0; b_if.req_addr = '0; b_if.req_wdata = '0;
        @(posedge clk); #1;
        check_reset_a("rst0");
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single write from requester 0
        drive_a(0, 1'b1, 8'hB2, 16'h0003, 8'h5A);
        eng_len_a = 20;
        push_a(0, 1'b0, 1'b0, 8'h00);
        @(negedge clk); a_if.req[0] = 1'b1;
        @(posedge clk); #1;
        check("t1_gnt_at_1",   32'(a_if.gnt),       32'd1);
        check("t1_trig_not_1", 32'(a_if.iic_trig),  32'd0);
        check("t1_w_r",        32'(a_if.w_r),       32'd1);
        check("t1_device_id",  32'(a_if.device_id), 32'hB2);
        check("t1_addr",       32'(a_if.addr),      32'h0003);
        check("t1_data_in",    32'(a_if.data_in),   32'h5A);
        @(posedge clk); #1;
        check("t1_trig_at_2",  32'(a_if.iic_trig),  32'd1);
        wait_done(0, 1, 100, "t1_done");
        a_if.req[0] = 1'b0;

        // 2: read from requester 1
        drive_a(1, 1'b0, 8'hB3, 16'h0502, 8'h00);
        eng_rd_a = 8'h3C;
        push_a(1, 1'b0, 1'b1, 8'h3C);
        @(negedge clk); a_if.req[1] = 1'b1;
        @(posedge clk); #1;
        check("t2_gnt",  32'(a_if.gnt),  32'd2);
        check("t2_w_r",  32'(a_if.w_r),  32'd0);
        check("t2_addr", 32'(a_if.addr), 32'h0502);
        wait_done(0, 2, 100, "t2_done");
        a_if.req[1] = 1'b0;

        // 3: contention, both held for four transactions -> 0,1,0,1
        drive_a(0, 1'b1, 8'hB2, 16'h0010, 8'h11);
        drive_a(1, 1'b1, 8'hB2, 16'h0011, 8'h22);
        eng_len_a = 6;
        for (int i = 0; i < 4; i++) push_a(i % 2, 1'b0, 1'b0, 8'h00);
        @(negedge clk); a_if.req = 2'b11;
        wait_done(0, 6, 400, "t3_done");
        a_if.req = 2'b00;
        repeat (4) @(negedge clk);

        // 5: reset while the engine is busy
        drive_a(1, 1'b0, 8'hB3, 16'h0100, 8'h00);
        eng_rd_a = 8'h99; eng_len_a = 20;
        @(negedge clk); a_if.req[1] = 1'b1;
        wait_busy_a(1'b1, 50, "t5_busy_rise");
        repeat (3) @(negedge clk);
        check("t5_gnt_mid_run", 32'(a_if.gnt), 32'd2);
        rst_a = 1'b1; a_if.req = 2'b00;
        #1;
        check_reset_a("t5_async");
        wait_busy_a(1'b0, 100, "t5_busy_fall");
        @(negedge clk);
        model_rd_a = 8'h00;
        rst_a = 1'b0;
        drive_a(1, 1'b0, 8'hB3, 16'h0101, 8'h00);
        eng_rd_a = 8'h77;
        push_a(1, 1'b0, 1'b1, 8'h77);
        @(negedge clk); a_if.req[1] = 1'b1;
        wait_done(0, 7, 100, "t5_after_reset_done");
        a_if.req[1] = 1'b0;

        // 6: req[0] dropped (and inputs changed) during RUN
        drive_a(0, 1'b1, 8'hB2, 16'h0200, 8'h66);
        eng_len_a = 10;
        push_a(0, 1'b0, 1'b0, 8'h00);
        @(negedge clk); a_if.req[0] = 1'b1;
        wait_busy_a(1'b1, 50, "t6_busy_rise");
        @(negedge clk);
        a_if.req[0] = 1'b0;
        drive_a(0, 1'b0, 8'hFF, 16'hFFFF, 8'hFF);
        @(posedge clk); #1;
        check("t6_addr_stable",    32'(a_if.addr),    32'h0200);
        check("t6_data_in_stable", 32'(a_if.data_in), 32'h66);
        wait_done(0, 8, 100, "t6_done");
        repeat (10) @(negedge clk);
        check("t6_no_regrant", 32'(a_if.gnt), 32'd0);
        check("t6_done_once",  32'(done_cnt_a), 32'd8);

        // 4: timeout on the TMO_CYC=16 instance, then a normal transfer
        eng_en_b = 1'b0;
        b_if.req_wr[0] = 1'b1; b_if.req_dev[7:0] = 8'hB2; b_if.req_addr[15:0] = 16'h0004; b_if.req_wdata[7:0] = 8'h44;
        push_b(0, 1'b1, 1'b0, 8'h00);
        @(negedge clk); b_if.req[0] = 1'b1;
        wait_done(1, 1, 100, "t4_tmo_done");
        b_if.req[0] = 1'b0;
        eng_en_b = 1'b1;
        repeat (2) @(negedge clk);
        b_if.req_addr[15:0] = 16'h0005;
        push_b(0, 1'b0, 1'b0, 8'h00);
        @(negedge clk); b_if.req[0] = 1'b1;
        wait_done(1, 2, 100, "t4_next_done");
        b_if.req[0] = 1'b0;
        repeat (4) @(negedge clk);

        check("a_grant_count",    32'(gnt_cnt_a),  32'd9);
        check("a_trig_per_grant", 32'(trig_cnt_a), 32'(gnt_cnt_a));
        check("a_queue_empty",    32'(qa.size()),  32'd0);
        check("b_trig_count",     32'(trig_cnt_b), 32'd2);
        check("b_queue_empty",    32'(qb.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
